// File: rtl/seq_squarer_if.sv
// -----------------------------------------------------------------------------
// seq_squarer_if
//   Handshake and result bundle for the sequential squarer.
//
//   Signals
//     start  : request to square the value on a (driven by the master)
//     a      : WIDTH-bit unsigned operand (driven by the master)
//     busy   : computation in progress (driven by the squarer)
//     done   : single-cycle completion pulse (driven by the squarer)
//     square : 2*WIDTH-bit result, held until the next accepted start
//
//   Modports
//     master : the requester side (drives start/a, observes results)
//     slave  : the squarer side
// -----------------------------------------------------------------------------
interface seq_squarer_if #(
    parameter int WIDTH = 4
);
    logic                 start;
    logic [WIDTH-1:0]     a;
    logic                 busy;
    logic                 done;
    logic [2*WIDTH-1:0]   square;

    modport master (
        output start, a,
        input  busy, done, square
    );

    modport slave (
        input  start, a,
        output busy, done, square
    );
endinterface

// File: rtl/seq_squarer.sv
// -----------------------------------------------------------------------------
// seq_squarer
//   Computes a*a with a shift-and-add loop, one operand bit per clock.
//   A request is accepted in IDLE, the loop runs for exactly WIDTH cycles in
//   CALC, and the result is published on entry to DONE together with a
//   one-cycle done pulse. Latency is fixed regardless of the operand value.
//
//   Ports
//     clk : system clock, rising edge
//     rst : asynchronous, active-high reset
//     bus : seq_squarer_if slave modport (start, a, busy, done, square)
//
//   Parameters
//     WIDTH : operand width in bits, 2..16
// -----------------------------------------------------------------------------
module seq_squarer #(
    parameter int WIDTH = 4
) (
    input  logic          clk,
    input  logic          rst,
    seq_squarer_if.slave  bus
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_q;
    logic [WIDTH-1:0]     operand_q;
    logic [2*WIDTH-1:0]   acc_q;
    logic [CW-1:0]        cnt_q;
    logic [2*WIDTH-1:0]   square_q;
    logic                 busy_q;
    logic                 done_q;

    // Accumulator value after processing the current operand bit. The
    // operand is zero-extended to 2*WIDTH before shifting so no partial
    // product bits are lost; the final sum fits since (2^W-1)^2 < 2^(2W).
    logic [2*WIDTH-1:0]   acc_d;

    // NOTE: every variable assigned in a combinational block gets a default
    // first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        acc_d = acc_q;
        if (operand_q[cnt_q]) begin
            acc_d = acc_q + ({{WIDTH{1'b0}}, operand_q} << cnt_q);
        end
    end

    // NOTE: all state, including the datapath registers, is cleared by the
    // asynchronous reset so an aborted computation leaves nothing behind.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            operand_q <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            square_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        operand_q <= bus.a;
                        acc_q     <= '0;
                        cnt_q     <= '0;
                        busy_q    <= 1'b1;
                        state_q   <= CALC;
                    end
                end

                // start and a are not looked at here, so requests made while
                // busy are dropped and operand changes cannot disturb the loop.
                CALC: begin
                    acc_q <= acc_d;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_q == LAST_BIT) begin
                        square_q <= acc_d;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end

                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end

                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.busy   = busy_q;
    assign bus.done   = done_q;
    assign bus.square = square_q;

endmodule

// File: tb/tb_seq_squarer.sv
// -----------------------------------------------------------------------------
// tb_seq_squarer
//   Drives a WIDTH=4 and a WIDTH=8 squarer from shared clock/reset and
//   compares against a reference model: square = a*a, done raised on the
//   (WIDTH+1)-th rising edge counting the accepting edge as the first, busy
//   high for WIDTH+1 cycles, back-to-back period WIDTH+2.
// -----------------------------------------------------------------------------
module tb_seq_squarer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_r;
    logic [15:0] a_r;
    logic        sel8;

    int checks = 0;
    int errors = 0;

    // Model of the last published result per instance (0: WIDTH=4, 1: WIDTH=8).
    logic [15:0] last_sq [2];

    seq_squarer_if #(.WIDTH(4)) if4 ();
    seq_squarer_if #(.WIDTH(8)) if8 ();

    seq_squarer #(.WIDTH(4)) dut4 (.clk(clk), .rst(rst), .bus(if4.slave));
    seq_squarer #(.WIDTH(8)) dut8 (.clk(clk), .rst(rst), .bus(if8.slave));

    assign if4.start = start_r && !sel8;
    assign if4.a     = a_r[3:0];
    assign if8.start = start_r && sel8;
    assign if8.a     = a_r[7:0];

    logic        cur_busy;
    logic        cur_done;
    logic [15:0] cur_sq;
    assign cur_busy = sel8 ? if8.busy : if4.busy;
    assign cur_done = sel8 ? if8.done : if4.done;
    assign cur_sq   = sel8 ? if8.square : {8'h00, if4.square};

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // One request on the selected instance. rep_edge > 0 re-pulses start with
    // rep_val after that many edges; toggle flips a every cycle while busy.
    task automatic run_op(input logic [15:0] av, input bit toggle,
                          input int rep_edge, input logic [15:0] rep_val);
        int          w;
        int          edges;
        int          busy_cnt;
        int          done_edge;
        int          done_cnt;
        bit          partial;
        logic [15:0] mask;
        logic [15:0] exp_sq;
        logic [15:0] sq_at_done;
        w      = sel8 ? 8 : 4;
        mask   = sel8 ? 16'h00FF : 16'h000F;
        exp_sq = (av & mask) * (av & mask);
        partial    = 1'b0;
        sq_at_done = '0;
        @(negedge clk);
        start_r = 1'b1;
        a_r     = av;
        @(posedge clk);
        #1;
        start_r   = 1'b0;
        edges     = 1;
        busy_cnt  = cur_busy ? 1 : 0;
        done_edge = 0;
        done_cnt  = 0;
        check("busy_after_accept", 32'(cur_busy), 32'd1);
        for (int i = 0; i < 40; i++) begin
            if (toggle) a_r = a_r ^ mask;
            if (edges == rep_edge) begin
                start_r = 1'b1;
                a_r     = rep_val;
            end
            @(posedge clk);
            #1;
            start_r = 1'b0;
            edges++;
            if (cur_busy) busy_cnt++;
            if (cur_done) begin
                done_cnt++;
                if (done_edge == 0) begin
                    done_edge  = edges;
                    sq_at_done = cur_sq;
                end
            end else if (done_edge == 0 && cur_sq != last_sq[sel8]) begin
                partial = 1'b1;
            end
            if (!cur_busy) break;
        end
        check("done_latency", 32'(done_edge), 32'(w + 1));
        check("busy_cycles", 32'(busy_cnt), 32'(w + 1));
        check("done_pulses", 32'(done_cnt), 32'd1);
        check("square_at_done", 32'(sq_at_done), 32'(exp_sq));
        check("square_held", 32'(cur_sq), 32'(exp_sq));
        check("no_partial_sum", 32'(partial), 32'd0);
        last_sq[sel8] = exp_sq;
    endtask

    initial begin
        int done_edges [$];
        int n_done;

        rst        = 1'b1;
        start_r    = 1'b0;
        a_r        = '0;
        sel8       = 1'b0;
        last_sq[0] = '0;
        last_sq[1] = '0;

        #12;
        check("rst_busy4", 32'(if4.busy), 32'd0);
        check("rst_done4", 32'(if4.done), 32'd0);
        check("rst_sq4", 32'(if4.square), 32'd0);
        check("rst_busy8", 32'(if8.busy), 32'd0);
        check("rst_sq8", 32'(if8.square), 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Exhaustive WIDTH=4 sweep, including the zero operand.
        for (int v = 0; v < 16; v++) run_op(16'(v), 1'b0, 0, 16'h0);

        // WIDTH=8 corner operands plus random ones.
        sel8 = 1'b1;
        run_op(16'd255, 1'b0, 0, 16'h0);
        run_op(16'd1, 1'b0, 0, 16'h0);
        for (int k = 0; k < 6; k++) run_op(16'($urandom_range(0, 255)), 1'b0, 0, 16'h0);

        // Second start two cycles into the computation must be ignored.
        sel8 = 1'b0;
        run_op(16'd9, 1'b0, 2, 16'd3);

        // Asynchronous reset in the middle of CALC.
        @(negedge clk);
        start_r = 1'b1;
        a_r     = 16'd7;
        @(posedge clk);
        #1;
        start_r = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("abort_busy", 32'(if4.busy), 32'd0);
        check("abort_done", 32'(if4.done), 32'd0);
        check("abort_square", 32'(if4.square), 32'd0);
        last_sq[0] = '0;
        last_sq[1] = '0;
        @(negedge clk);
        @(negedge clk);
        rst    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            if (if4.done) n_done++;
        end
        check("no_done_after_abort", 32'(n_done), 32'd0);
        run_op(16'd5, 1'b0, 0, 16'h0);

        // Operand toggling during CALC must not disturb the result.
        run_op(16'd12, 1'b1, 0, 16'h0);

        // start held high: a new request is accepted right after each done.
        @(negedge clk);
        start_r = 1'b1;
        a_r     = 16'd13;
        for (int e = 1; e <= 30; e++) begin
            @(posedge clk);
            #1;
            if (cur_done) begin
                done_edges.push_back(e);
                check("stream_square", 32'(cur_sq), 32'd169);
            end
        end
        start_r = 1'b0;
        check("stream_count", 32'(done_edges.size()), 32'd5);
        if (done_edges.size() > 0) check("stream_first", 32'(done_edges[0]), 32'd5);
        for (int j = 1; j < done_edges.size(); j++)
            check("stream_period", 32'(done_edges[j] - done_edges[j-1]), 32'd6);
        n_done = 0;
        for (int i = 0; i < 20 && cur_busy; i++) begin
            @(posedge clk);
            #1;
        end
        check("stream_idle", 32'(cur_busy), 32'd0);
        last_sq[0] = 16'd169;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
